// File: rtl/recon_by_five_pkg.sv
// Shared types and constants for the 5*q + r reconstruction block.
package recon_by_five_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACC  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int unsigned ITERATIONS = 5;
  localparam int unsigned MAX_REM    = 4;

endpackage

// File: rtl/recon_by_five_control.sv
// Sequencing FSM: accept a pair, add q five times, hold the result until taken.
//   state | meaning
//   IDLE  | ready for a new quotient/remainder pair
//   ACC   | adding q into the accumulator, one addition per cycle
//   DONE  | result presented, waiting for out_rdy
module recon_by_five_control
  import recon_by_five_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic in_val,
  input  logic out_rdy,
  input  logic cnt_done,
  output logic in_rdy,
  output logic out_val,
  output logic load_en,
  output logic acc_en
);

  state_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    out_val   = 1'b0;
    load_en   = 1'b0;
    acc_en    = 1'b0;
    case (state)
      IDLE: begin
        in_rdy = 1'b1;
        if (in_val) begin
          load_en   = 1'b1;
          state_nxt = ACC;
        end
      end
      ACC: begin
        acc_en = 1'b1;
        if (cnt_done) state_nxt = DONE;
      end
      DONE: begin
        out_val = 1'b1;
        if (out_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/recon_by_five.sv
// Reconstructs 5*q + r by repeated addition; inverse of the divide-by-five unit.
module recon_by_five
  import recon_by_five_pkg::*;
#(
  parameter int NBITS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_val,
  output logic               in_rdy,
  input  logic [NBITS-1:0]   in_q,
  input  logic [2:0]         in_r,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [NBITS+2:0]   out_data,
  output logic               out_err
);

  localparam int W = NBITS + 3;

  logic [NBITS-1:0] q_reg;
  logic [W-1:0]     acc;
  logic [2:0]       cnt;
  logic             err;
  logic             cnt_done;
  logic             load_en;
  logic             acc_en;

  // Counter value seen on the last of the five ACC edges.
  assign cnt_done = (cnt == 3'(ITERATIONS - 1));

  recon_by_five_control u_control (
    .clk      (clk),
    .rst      (rst),
    .in_val   (in_val),
    .out_rdy  (out_rdy),
    .cnt_done (cnt_done),
    .in_rdy   (in_rdy),
    .out_val  (out_val),
    .load_en  (load_en),
    .acc_en   (acc_en)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg <= '0;
      acc   <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else if (load_en) begin
      q_reg <= in_q;
      acc   <= {{NBITS{1'b0}}, in_r};
      err   <= (in_r > 3'(MAX_REM));
      cnt   <= '0;
    end else if (acc_en) begin
      acc <= acc + W'(q_reg);
      cnt <= cnt + 3'd1;
    end
  end

  assign out_data = out_val ? acc : '0;
  assign out_err  = out_val & err;

endmodule

// File: tb/tb_recon_by_five.sv
// Scoreboard bench for recon_by_five: driver pushes 5q+r expectations, monitor pops on handshake.
module tb_recon_by_five;

  localparam int NBITS = 8;

  typedef struct {
    int data;
    bit err;
    int acc_edge;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_val = 1'b0;
  logic             in_rdy;
  logic [NBITS-1:0] in_q = '0;
  logic [2:0]       in_r = '0;
  logic             out_val;
  logic             out_rdy = 1'b1;
  logic [NBITS+2:0] out_data;
  logic             out_err;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   last_accept = -1;
  bit   b2b = 1'b0;

  recon_by_five #(.NBITS(NBITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .in_q     (in_q),
    .in_r     (in_r),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .out_data (out_data),
    .out_err  (out_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Present a pair from the next falling edge until it is taken.
  task automatic send(input int q, input int r, input bit hold, input bit release_rst);
    bit done = 1'b0;
    int n = 0;
    exp_t e;
    while (!done && n < 100) begin
      @(negedge clk);
      if (release_rst) rst = 1'b0;
      in_val = 1'b1;
      in_q = NBITS'(q);
      in_r = 3'(r);
      #1;
      if (in_rdy && !rst) begin
        done = 1'b1;
        e.data = 5 * q + r;
        e.err = (r > 4);
        e.acc_edge = cyc + 1;
        exp_q.push_back(e);
        if (b2b && last_accept >= 0) check("accept_spacing", e.acc_edge - last_accept, 7);
        last_accept = e.acc_edge;
      end
      n++;
    end
    if (!done) check("accept_timeout", 0, 1);
    if (!hold) begin
      @(negedge clk);
      in_val = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
  endtask

  // Monitor: samples just after the falling edge, when out_rdy for the next edge is settled.
  initial begin
    bit prev_val = 1'b0;
    int held_data = 0;
    bit held_err = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!out_val) begin
        check("idle_data_zero", int'(out_data), 0);
        check("idle_err_zero", int'(out_err), 0);
      end else if (!prev_val) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", int'(out_data), -1);
        end else begin
          e = exp_q[0];
          check("latency", cyc - e.acc_edge, 5);
          check("out_data", int'(out_data), e.data);
          check("out_err", int'(out_err), int'(e.err));
        end
        held_data = int'(out_data);
        held_err = out_err;
      end else begin
        check("held_data", int'(out_data), held_data);
        check("held_err", int'(out_err), int'(held_err));
      end
      if (out_val && out_rdy && !rst && exp_q.size() != 0) void'(exp_q.pop_front());
      prev_val = out_val;
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_rdy", int'(in_rdy), 1);
    check("rst_out_val", int'(out_val), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_err", int'(out_err), 0);

    // Basic case, accepted on the first edge after reset release.
    send(7, 3, 1'b0, 1'b1);
    drain();

    send(0, 0, 1'b0, 1'b0);
    drain();
    send(255, 4, 1'b0, 1'b0);
    drain();
    send(10, 6, 1'b0, 1'b0);
    drain();

    // Backpressure: result held for 10 cycles while a competing pair is offered.
    @(negedge clk);
    out_rdy = 1'b0;
    send(3, 1, 1'b0, 1'b0);
    n = 0;
    while (!out_val && n < 20) begin
      @(negedge clk);
      in_val = 1'b1;
      in_q = 8'd99;
      in_r = 3'd0;
      #1;
      check("bp_acc_in_rdy", int'(in_rdy), 0);
      n++;
    end
    check("bp_out_val_seen", int'(out_val), 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      check("bp_in_rdy", int'(in_rdy), 0);
      check("bp_out_val", int'(out_val), 1);
      check("bp_data", int'(out_data), 16);
    end
    @(negedge clk);
    in_val = 1'b0;
    out_rdy = 1'b1;
    drain();

    // Reset on the third ACC cycle discards the operation.
    send(5, 2, 1'b1, 1'b0);
    @(negedge clk);
    in_val = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_in_rdy", int'(in_rdy), 1);
    check("mid_rst_out_val", int'(out_val), 0);
    check("mid_rst_out_data", int'(out_data), 0);
    send(2, 2, 1'b0, 1'b0);
    drain();

    // Back-to-back random pairs with in_val held high.
    b2b = 1'b1;
    last_accept = -1;
    for (int i = 0; i < 20; i++)
      send(int'($urandom_range(0, 255)), int'($urandom_range(0, 7)), (i != 19), 1'b0);
    b2b = 1'b0;
    drain();

    // Random operands with random consumer stalls.
    for (int i = 0; i < 10; i++) begin
      send(int'($urandom_range(0, 255)), int'($urandom_range(0, 7)), 1'b0, 1'b0);
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
        @(negedge clk);
        out_rdy = ($urandom_range(0, 2) == 0);
        n++;
      end
      if (exp_q.size() != 0) check("stall_timeout", exp_q.size(), 0);
      out_rdy = 1'b1;
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
